stdout_hex_tx: RTL and testbench

// - Consumer end of the core's stdout stdio handshake (val/data/rdy, 16-bit words).
// - Buffers words in a small FIFO and renders each one as 4 uppercase ASCII hex digits,
//   MSB nibble first, followed by a line terminator.
// - Emits the result as a byte stream with a val/rdy handshake, typically to a UART TX.
// - Sits between core.stdout_intf and the host serial link.

---
 rtl/stdout_hex_tx.sv | 152 +++++++++++++++
 tb/tb_stdout_hex_tx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stdout_hex_tx.sv
// stdout_hex_tx: takes 16-bit words from the core's stdout val/data/rdy port,
// queues them in a small word FIFO and streams each one out as four uppercase
// ASCII hex digits (MSB nibble first) followed by a line terminator.
//
// Build option: define STDOUT_HEX_CRLF_EN to terminate each line with CR LF.
// Without it the terminator is a single LF and the CR state does not exist.
//
// Word side:  a word is pushed on an edge where word_val_i & word_rdy_o.
//             word_rdy_o is a registered !full flag; a pop in the same cycle
//             does not make a full FIFO ready early.
// Byte side:  a byte moves on an edge where byte_val_o & byte_rdy_i.
//             While byte_val_o=1 and byte_rdy_i=0 the byte is held unchanged,
//             and byte_val_o only drops after a transfer (or on reset).
module stdout_hex_tx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        word_val_i,
    input  logic [15:0] word_data_i,
    output logic        word_rdy_o,
    output logic        byte_val_o,
    output logic [7:0]  byte_data_o,
    input  logic        byte_rdy_i,
    output logic        busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

`ifdef STDOUT_HEX_CRLF_EN
    typedef enum logic [1:0] {IDLE, HEX, CR, LF} state_t;
`else
    typedef enum logic [1:0] {IDLE, HEX, LF} state_t;
`endif

    // Uppercase ASCII for one hex nibble.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        else           return 8'h37 + {4'h0, n};
    endfunction

    // Word FIFO storage and pointers; pointers carry one extra wrap bit so
    // full and empty can be told apart when the index bits are equal.
    logic [15:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] wr_ptr_nxt;
    logic [AW:0] rd_ptr_nxt;
    logic        push;
    logic        pop;
    logic        empty;
    logic        full_nxt;
    logic [15:0] head;

    // Formatter state. sh holds the nibbles not yet presented, left-aligned;
    // the first digit is taken straight from the FIFO head when popping.
    state_t      state;
    logic [11:0] sh;
    logic [1:0]  nib_cnt;
    logic        xfer;

    assign head       = mem[rd_ptr[AW-1:0]];
    assign empty      = (wr_ptr == rd_ptr);
    assign push       = word_val_i & word_rdy_o;
    assign pop        = (state == IDLE) & ~empty;
    assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
    assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
    assign full_nxt   = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                        (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    assign xfer       = byte_val_o & byte_rdy_i;

    // Write accepted words into the FIFO storage (contents need no reset).
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= word_data_i;
    end

    // Advance FIFO pointers and register the ready flag from the next occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            word_rdy_o <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            word_rdy_o <= ~full_nxt;
        end
    end

    // Formatter FSM: pop a word, emit four hex digits, then the terminator.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            sh          <= '0;
            nib_cnt     <= '0;
            byte_val_o  <= 1'b0;
            byte_data_o <= 8'h00;
            busy_o      <= 1'b0;
        end else begin
            busy_o <= ~empty | (state != IDLE);
            case (state)
                IDLE: begin
                    if (!empty) begin
                        sh          <= head[11:0];
                        nib_cnt     <= 2'd3;
                        byte_val_o  <= 1'b1;
                        byte_data_o <= hex_ascii(head[15:12]);
                        state       <= HEX;
                    end
                end
                HEX: begin
                    if (xfer) begin
                        sh <= {sh[7:0], 4'h0};
                        if (nib_cnt == 2'd0) begin
`ifdef STDOUT_HEX_CRLF_EN
                            byte_data_o <= 8'h0D;
                            state       <= CR;
`else
                            byte_data_o <= 8'h0A;
                            state       <= LF;
`endif
                        end else begin
                            nib_cnt     <= nib_cnt - 2'd1;
                            byte_data_o <= hex_ascii(sh[11:8]);
                        end
                    end
                end
`ifdef STDOUT_HEX_CRLF_EN
                CR: begin
                    if (xfer) begin
                        byte_data_o <= 8'h0A;
                        state       <= LF;
                    end
                end
`endif
                LF: begin
                    if (xfer) begin
                        byte_val_o  <= 1'b0;
                        byte_data_o <= 8'h00;
                        state       <= IDLE;
                    end
                end
                default: begin
                    byte_val_o  <= 1'b0;
                    byte_data_o <= 8'h00;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stdout_hex_tx.sv
// Testbench for stdout_hex_tx. Expected bytes are queued when a word is
// accepted; a monitor pops and compares on every byte transfer.
module tb_stdout_hex_tx;

    logic        clk;
    logic        rst_i;
    logic        word_val_i;
    logic [15:0] word_data_i;
    logic        word_rdy_o;
    logic        byte_val_o;
    logic [7:0]  byte_data_o;
    logic        byte_rdy_i;
    logic        busy_o;

    logic [7:0]  exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_bytes = 0;
    int          rdy_mode = 0;  // 0 ready, 1 stall 5 cycles per byte, 2 random, 3 never
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    stdout_hex_tx #(.FIFO_DEPTH(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .word_val_i  (word_val_i),
        .word_data_i (word_data_i),
        .word_rdy_o  (word_rdy_o),
        .byte_val_o  (byte_val_o),
        .byte_data_o (byte_data_o),
        .byte_rdy_i  (byte_rdy_i),
        .busy_o      (busy_o)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_ascii(input logic [3:0] n);
        logic [7:0] tbl [16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                                 8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
        return tbl[n];
    endfunction

    task automatic push_term();
`ifdef STDOUT_HEX_CRLF_EN
        exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(8'h0A);
    endtask

    // Offer one word; when accepted, queue its expected bytes. lit holds the
    // four hand-computed ASCII digits when use_lit is set.
    task automatic push_word(input logic [15:0] w, input logic [31:0] lit, input bit use_lit);
        int t;
        bit ok;
        t  = 0;
        ok = 1'b0;
        word_val_i  = 1'b1;
        word_data_i = w;
        while (!ok && t < 200) begin
            @(negedge clk);
            ok = word_rdy_o;
            t++;
        end
        if (!ok) begin
            check("push_timeout", 32'(w), 32'hFFFF_FFFF);
            word_val_i = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            word_val_i = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (use_lit) exp_q.push_back(lit[31-8*i -: 8]);
                else         exp_q.push_back(model_ascii(w[15-4*i -: 4]));
            end
            push_term();
        end
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // ---------------- byte_rdy_i driver ----------------
    initial begin
        int cnt;
        cnt = 0;
        byte_rdy_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: byte_rdy_i = 1'b1;
                1: begin
                    if (!byte_val_o) begin
                        byte_rdy_i = 1'b0;
                        cnt = 0;
                    end else if (cnt == 5) begin
                        byte_rdy_i = 1'b1;
                        cnt = 0;
                    end else begin
                        byte_rdy_i = 1'b0;
                        cnt++;
                    end
                end
                2: byte_rdy_i = ($urandom_range(0, 2) != 0);
                default: byte_rdy_i = 1'b0;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_val_held", byte_val_o, 1'b1);
                    check("stall_data_held", byte_data_o, prev_data);
                end
                if (byte_val_o) check("busy_while_val", busy_o, 1'b1);
                if (byte_val_o && byte_rdy_i) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_byte: got %0h required none", byte_data_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", byte_data_o, e);
                    end
                    n_bytes++;
                end
                prev_stall = byte_val_o && !byte_rdy_i;
                prev_data  = byte_data_o;
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int  base;
        int  t;
        bit  early;
        rst_i       = 1'b1;
        word_val_i  = 1'b0;
        word_data_i = 16'h0000;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_word_rdy", word_rdy_o, 1'b0);
        check("rst_byte_val", byte_val_o, 1'b0);
        check("rst_byte_data", byte_data_o, 8'h00);
        check("rst_busy", busy_o, 1'b0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("word_rdy_after_rst", word_rdy_o, 1'b1);

        // 1. Basic word with first-digit latency
        @(posedge clk);
        #1;
        push_word(16'h1A2F, 32'h3141_3246, 1'b1);
        @(negedge clk);
        check("latency_pop_edge", byte_val_o, 1'b0);
        @(negedge clk);
        check("latency_first_val", byte_val_o, 1'b1);
        check("latency_first_data", byte_data_o, 8'h31);
        wait_drain("drain_basic");

        // 2. Back-pressure, 5 stall cycles on every byte
        rdy_mode = 1;
        push_word(16'h00F9, 32'h3030_4639, 1'b1);
        wait_drain("drain_backpressure");
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;

        // 3. FIFO full: four words in the FIFO plus one held by the formatter
        rdy_mode = 3;
        @(posedge clk);
        #1;
        push_word(16'h0123, 32'h3031_3233, 1'b1);
        push_word(16'h4567, 32'h3435_3637, 1'b1);
        push_word(16'h89AB, 32'h3839_4142, 1'b1);
        push_word(16'hCDEF, 32'h4344_4546, 1'b1);
        push_word(16'h1357, 32'h3133_3537, 1'b1);
        @(negedge clk);
        check("full_word_rdy", word_rdy_o, 1'b0);
        check("full_busy", busy_o, 1'b1);
        word_val_i  = 1'b1;
        word_data_i = 16'h2468;
        early = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (word_rdy_o) early = 1'b1;
        end
        check("full_word_held", early, 1'b0);
        rdy_mode = 0;
        push_word(16'h2468, 32'h3234_3638, 1'b1);
        wait_drain("drain_full");

        // 4. Boundary values
        push_word(16'h0000, 32'h3030_3030, 1'b1);
        push_word(16'hFFFF, 32'h4646_4646, 1'b1);
        push_word(16'h9ABC, 32'h3941_4243, 1'b1);
        wait_drain("drain_boundary");
        repeat (3) @(posedge clk);
        #1;

        // 5. Reset after the second byte ('2') of 16'h1234 transfers
        base = n_bytes;
        push_word(16'h1234, 32'h3132_3334, 1'b1);
        push_word(16'h5678, 32'h3536_3738, 1'b1);
        t = 0;
        while (n_bytes < base + 2 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("midword_reached", n_bytes - base, 2);
        rst_i = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("midrst_byte_val", byte_val_o, 1'b0);
        check("midrst_busy", busy_o, 1'b0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        push_word(16'hBEEF, 32'h4245_4546, 1'b1);
        wait_drain("drain_after_reset");
        repeat (4) @(posedge clk);
        #1;
        check("idle_after_reset_word", byte_val_o, 1'b0);

        // 6. Streaming with random gaps and random byte_rdy_i
        rdy_mode = 2;
        for (int i = 0; i < 64; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            push_word(16'($urandom_range(0, 65535)), 32'h0, 1'b0);
        end
        wait_drain("drain_stream");
        check("busy_at_last_lf", busy_o, 1'b1);
        t = 0;
        while (busy_o && t < 10) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("busy_fall_end", busy_o, 1'b0);
        check("val_low_end", byte_val_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
